vga_rect_renderer: RTL
======================

Name: vga_rect_renderer

Overview:
Pixel-generation stage directly downstream of the VGA timing generator. Consumes its x/y/active/hs/vs stream and produces 2-bit-per-channel RGB plus delay-matched syncs for the output pins. Colour comes from a small table of axis-aligned rectangles written by the host-command front end, with one background colour behind them. Writes land in shadow registers and become visible only at frame start, so the image never tears.

Parameters:
NUM_RECTS, 4, number of rectangle entries (1..8)
IDX_W, 2, width of wr_index; equals clog2(NUM_RECTS), minimum 1

Ports:
clk  in  1  pixel clock, same clock as the timing generator
rst  in  1  synchronous reset, active-high
in_hs  in  1  horizontal sync from timing generator
in_vs  in  1  vertical sync from timing generator
in_x  in  10  current column counter
in_y  in  9  current row counter
in_active  in  1  active-video flag
bg_color  in  6  background colour {r[1:0],g[1:0],b[1:0]}, sampled every cycle
wr_valid  in  1  rectangle write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_index  in  IDX_W  target entry
wr_x0  in  10  left edge, inclusive
wr_x1  in  10  right edge, exclusive
wr_y0  in  9  top edge, inclusive
wr_y1  in  9  bottom edge, exclusive
wr_color  in  6  fill colour {r,g,b}
wr_enable  in  1  entry visible flag
wr_outline  in  1  outline-only flag (see Optional Feature)
out_r  out  2  red
out_g  out  2  green
out_b  out  2  blue
out_hs  out  1  in_hs delayed 2 cycles
out_vs  out  1  in_vs delayed 2 cycles
out_active  out  1  in_active delayed 2 cycles
commit_pulse  out  1  one-cycle pulse when shadow table is copied to live table

Behaviour:
- Reset (rst=1 at a clk edge): all shadow and live entries cleared, with enable=0 and all fields 0. pending=0. Pipeline cleared. out_r/g/b=0, out_hs=0, out_vs=0, out_active=0, commit_pulse=0, wr_ready=0 during reset. Reset takes effect on the next edge regardless of in-flight writes or frame position.
- Write port: wr_ready=1 in every non-reset cycle except the commit cycle. An accepted write updates shadow[wr_index] on that edge and sets pending=1. wr_index >= NUM_RECTS: the write is accepted and dropped, and pending is unchanged. Multiple writes per frame are allowed; the last one wins.
- Commit: a frame-start cycle has in_x==0 && in_y==0. In a frame-start cycle with pending=1:
  - live <= shadow, pending <= 0, commit_pulse=1 on the next cycle.
  - wr_ready=0 in that cycle, so no write collides with the copy.
  In a frame-start cycle with pending=0: no copy, no pulse, wr_ready stays 1.
- Hit test for entry i, combinational on live[i]: enable && x0<=in_x<x1 && y0<=in_y<y1, with unsigned compares. x1<=x0 or y1<=y0 gives an empty rectangle that never hits.
- Priority: lowest index with a hit supplies the colour. No hit selects bg_color.
- Pipeline, fixed latency 2:
  - Stage 1 registers the per-entry hit vector, the entry colours, in_active, hs and vs.
  - Stage 2 registers the priority-selected colour.
  - RGB is forced to 0 when the stage-2 active flag is 0, i.e. blanking outputs black.
  - out_hs, out_vs and out_active pass through the same two register stages, so they stay aligned with RGB.
- Coordinates are raw counter values; the rectangle table is expressed in counter space, including porches and sync.
- The live table changes only at a commit edge, so a displayed frame always uses a single table snapshot.

Optional Feature:
Macro RECT_OUTLINE_EN.
- Defined: each entry stores an outline bit, taken from wr_outline. An outline entry hits only if its filled hit is true and (in_x==x0 || in_x==x1-1 || in_y==y0 || in_y==y1-1). Priority and latency are unchanged.
- Undefined: wr_outline is ignored, no storage is built for it, and every entry renders filled.

Test Plan:
- Reset, then free-run 1 frame with bg_color=6'b000011, no writes -> out_b=2'b11 and out_r/g=0 on every active cycle, RGB=0 when out_active=0, commit_pulse never fires.
- Write entry 0 = {x0=200,x1=210,y0=100,y1=105,color=6'b110000,enable=1} mid-frame -> no change in the current frame. At next in_x=0,in_y=0: wr_ready=0 for that cycle, commit_pulse next cycle. In the following frame out_r=2'b11 exactly 2 cycles after in_x in 200..209 with in_y in 100..104, and background elsewhere.
- Overlap: entry 1 red 150..250, entry 0 green 200..300 on same rows -> columns 200..249 green (index 0 wins), 150..199 red, 250..299 green.
- Degenerate/out-of-range: entry with x1=x0=300 never hits; write with wr_index=NUM_RECTS produces no commit_pulse at next frame start.
- Sync alignment: toggle in_hs/in_vs/in_active at arbitrary cycles -> outputs replicate them exactly 2 cycles later. Assert rst mid-line -> all outputs 0 the next cycle and the table cleared.
- With RECT_OUTLINE_EN: outlined rect 200..209 x 100..104 -> hits only at x=200/209 or y=100/104. Interior pixel (205,102) shows bg_color.

Source files
------------

// File: rtl/vga_rect_renderer_if.sv
// Rectangle-table write port between the host-command front end and vga_rect_renderer.
interface vga_rect_renderer_if #(
  parameter int IDX_W = 2
);
  logic             wr_valid;
  logic             wr_ready;
  logic [IDX_W-1:0] wr_index;
  logic [9:0]       wr_x0;
  logic [9:0]       wr_x1;
  logic [8:0]       wr_y0;
  logic [8:0]       wr_y1;
  logic [5:0]       wr_color;
  logic             wr_enable;
  logic             wr_outline;

  modport master (
    output wr_valid, wr_index, wr_x0, wr_x1, wr_y0, wr_y1, wr_color, wr_enable, wr_outline,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_index, wr_x0, wr_x1, wr_y0, wr_y1, wr_color, wr_enable, wr_outline,
    output wr_ready
  );
endinterface

// File: rtl/vga_rect_renderer.sv
// Rectangle-table pixel generator with frame-start shadow commit and a 2-stage pipeline.
// Optional outline-only entries are built when RECT_OUTLINE_EN is defined.
module vga_rect_renderer #(
  parameter int NUM_RECTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_hs,
  input  logic                in_vs,
  input  logic [9:0]          in_x,
  input  logic [8:0]          in_y,
  input  logic                in_active,
  input  logic [5:0]          bg_color,
  vga_rect_renderer_if.slave  wr,
  output logic [1:0]          out_r,
  output logic [1:0]          out_g,
  output logic [1:0]          out_b,
  output logic                out_hs,
  output logic                out_vs,
  output logic                out_active,
  output logic                commit_pulse
);

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] x1;
    logic [8:0] y0;
    logic [8:0] y1;
    logic [5:0] color;
    logic       enable;
`ifdef RECT_OUTLINE_EN
    logic       outline;
`endif
  } rect_t;

  rect_t shadow_q [NUM_RECTS];
  rect_t shadow_d [NUM_RECTS];
  rect_t live_q   [NUM_RECTS];
  rect_t live_d   [NUM_RECTS];
  logic  pending_q, pending_d;

  logic  frame_start, commit, wr_fire, idx_ok;
  rect_t new_entry;

  assign frame_start = (in_x == 10'd0) && (in_y == 9'd0);
  assign commit      = frame_start && pending_q;
  assign wr.wr_ready = !rst && !commit;
  assign wr_fire     = wr.wr_valid && wr.wr_ready;
  assign idx_ok      = int'(wr.wr_index) < NUM_RECTS;

  always_comb begin
    new_entry         = '0;
    new_entry.x0      = wr.wr_x0;
    new_entry.x1      = wr.wr_x1;
    new_entry.y0      = wr.wr_y0;
    new_entry.y1      = wr.wr_y1;
    new_entry.color   = wr.wr_color;
    new_entry.enable  = wr.wr_enable;
`ifdef RECT_OUTLINE_EN
    new_entry.outline = wr.wr_outline;
`endif
  end

  // NOTE: every output of a combinational block is given a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    shadow_d  = shadow_q;
    live_d    = live_q;
    pending_d = pending_q;
    if (commit) begin
      live_d    = shadow_q;
      pending_d = 1'b0;
    end else if (wr_fire && idx_ok) begin
      shadow_d[wr.wr_index] = new_entry;
      pending_d             = 1'b1;
    end
  end

  // NOTE: the table is only NUM_RECTS small entries of flops, so it is reset like any other state rather than left as an uninitialised memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        shadow_q[i] <= '0;
        live_q[i]   <= '0;
      end
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      live_q    <= live_d;
      pending_q <= pending_d;
    end
  end

  logic [NUM_RECTS-1:0] hit_d;

  // Unsigned compares make x1<=x0 or y1<=y0 an empty rectangle for free.
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < NUM_RECTS; i++) begin
      hit_d[i] = live_q[i].enable
              && (in_x >= live_q[i].x0) && (in_x < live_q[i].x1)
              && (in_y >= live_q[i].y0) && (in_y < live_q[i].y1);
`ifdef RECT_OUTLINE_EN
      if (live_q[i].outline)
        hit_d[i] = hit_d[i]
                && ((in_x == live_q[i].x0) || (in_x == live_q[i].x1 - 10'd1)
                 || (in_y == live_q[i].y0) || (in_y == live_q[i].y1 - 9'd1));
`endif
    end
  end

  logic [NUM_RECTS-1:0] hit_q;
  logic [5:0]           color_q [NUM_RECTS];
  logic [5:0]           bg_q;
  logic                 act1_q, hs1_q, vs1_q;
  logic [5:0]           rgb_q, rgb_d;
  logic                 act2_q, hs2_q, vs2_q;
  logic                 pulse_q;

  // Walk from the highest index down so the lowest hitting entry is the last to overwrite.
  always_comb begin
    rgb_d = bg_q;
    for (int i = NUM_RECTS - 1; i >= 0; i--)
      if (hit_q[i]) rgb_d = color_q[i];
  end

  // NOTE: all state below uses non-blocking assignments so each stage samples the previous stage's value from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q   <= '0;
      for (int i = 0; i < NUM_RECTS; i++) color_q[i] <= '0;
      bg_q    <= '0;
      act1_q  <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      rgb_q   <= '0;
      act2_q  <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      hit_q   <= hit_d;
      for (int i = 0; i < NUM_RECTS; i++) color_q[i] <= live_q[i].color;
      bg_q    <= bg_color;
      act1_q  <= in_active;
      hs1_q   <= in_hs;
      vs1_q   <= in_vs;
      rgb_q   <= rgb_d;
      act2_q  <= act1_q;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      pulse_q <= commit;
    end
  end

  assign {out_r, out_g, out_b} = act2_q ? rgb_q : 6'd0;
  assign out_hs       = hs2_q;
  assign out_vs       = vs2_q;
  assign out_active   = act2_q;
  assign commit_pulse = pulse_q;

endmodule
